// File: rtl/is_array_ctrl.sv
// is_array_ctrl: sequencer for an input-stationary ROWS x COLS systolic MAC array.
//
// A job runs through three phases:
//   LOAD   - ROWS cycles, one stationary input row per cycle (one-hot row enable)
//   STREAM - N cycles, one weight vector per cycle with the array processing
//   DRAIN  - L = ROWS+COLS-1 cycles, the array keeps processing so results flush out
// It then spends one cycle in DONE with a done pulse.
//
// out_valid marks finished psum vectors at the bottom of the array. It is high
// for N cycles, starting L cycles after the first STREAM cycle.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start, i_num_vec       job start (sampled in IDLE only), vector count N
//   i_abort                  cancel the job; returns to IDLE without a done pulse
//   o_busy, o_done           status; done is a single-cycle pulse
//   o_in_rd_en, o_in_rd_addr input buffer read strobe / row address
//   o_input_en               one-hot row load enable to the PE array
//   o_w_rd_en, o_w_rd_addr   weight buffer read strobe / vector address
//   o_process_en             PE process enable, broadcast
//   o_out_valid, o_out_addr  finished psum vector flag / output buffer address
//   o_state                  current FSM state, for debug and checkers
// Every output comes straight from a register.
module is_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_vec,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_in_rd_en,
  output logic [CNT_W-1:0] o_in_rd_addr,
  output logic [ROWS-1:0]  o_input_en,
  output logic             o_w_rd_en,
  output logic [CNT_W-1:0] o_w_rd_addr,
  output logic             o_process_en,
  output logic             o_out_valid,
  output logic [CNT_W-1:0] o_out_addr,
  output logic [2:0]       o_state
);

  // The timeline counter runs from the first STREAM cycle up to N+L. It must
  // hold (2^CNT_W - 1) + L without wrapping.
  localparam int LAT = ROWS + COLS - 1;
  localparam int T_W = $clog2((1 << CNT_W) + LAT);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [T_W-1:0] L_T      = T_W'(LAT);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_row;
  logic [T_W-1:0]   r_t;
  logic [CNT_W-1:0] r_n;

  state_t           w_state_nxt;
  logic [RW-1:0]    w_row_nxt;
  logic [T_W-1:0]   w_t_nxt;
  logic [CNT_W-1:0] w_n_nxt;
  logic [T_W-1:0]   w_n_ext;
  logic [T_W-1:0]   w_n_nxt_ext;
  logic             w_load;
  logic             w_stream;
  logic             w_drain;
  logic             w_out_valid;
  logic [T_W-1:0]   w_out_idx;

  assign w_n_ext     = T_W'(r_n);
  assign w_n_nxt_ext = T_W'(w_n_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_t_nxt     = r_t;
    w_n_nxt     = r_n;
    unique case (r_state)
      S_IDLE: begin
        // abort beats start in IDLE, so the job never begins
        if (i_start && !i_abort) begin
          w_n_nxt     = i_num_vec;
          w_row_nxt   = '0;
          w_t_nxt     = '0;
          w_state_nxt = (i_num_vec == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_row == ROW_LAST) begin
          w_row_nxt   = '0;
          w_t_nxt     = '0;
          w_state_nxt = S_STREAM;
        end else begin
          w_row_nxt = r_row + RW'(1);
        end
      end
      S_STREAM: begin
        w_t_nxt = r_t + T_W'(1);
        if (r_t == w_n_ext - T_W'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_t_nxt = r_t + T_W'(1);
        if (r_t == w_n_ext + L_T - T_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_t_nxt     = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // abort clears everything, which also flushes the pending out_valid window
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_t_nxt     = '0;
      w_n_nxt     = '0;
    end
  end

  // Outputs are decoded from the next-state values so that they are registered
  // and still line up with the state they belong to.
  assign w_load      = (w_state_nxt == S_LOAD);
  assign w_stream    = (w_state_nxt == S_STREAM);
  assign w_drain     = (w_state_nxt == S_DRAIN);
  assign w_out_valid = (w_stream || w_drain) && (w_t_nxt >= L_T) &&
                       (w_t_nxt < w_n_nxt_ext + L_T);
  assign w_out_idx   = w_t_nxt - L_T;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_t          <= '0;
      r_n          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_in_rd_en   <= 1'b0;
      o_in_rd_addr <= '0;
      o_input_en   <= '0;
      o_w_rd_en    <= 1'b0;
      o_w_rd_addr  <= '0;
      o_process_en <= 1'b0;
      o_out_valid  <= 1'b0;
      o_out_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_t          <= w_t_nxt;
      r_n          <= w_n_nxt;
      o_busy       <= (w_state_nxt != S_IDLE);
      o_done       <= (w_state_nxt == S_DONE);
      o_in_rd_en   <= w_load;
      o_in_rd_addr <= w_load ? CNT_W'(w_row_nxt) : '0;
      o_input_en   <= w_load ? (ROWS'(1) << w_row_nxt) : '0;
      o_w_rd_en    <= w_stream;
      o_w_rd_addr  <= w_stream ? CNT_W'(w_t_nxt) : '0;
      o_process_en <= w_stream || w_drain;
      o_out_valid  <= w_out_valid;
      o_out_addr   <= w_out_valid ? CNT_W'(w_out_idx) : '0;
    end
  end

  assign o_state = r_state;

endmodule
